// File: rtl/req_encoder_if.sv
// Request/grant bundle for req_encoder: raw request events in, encoded index out with a
// ready/valid handshake, plus pending vector and sticky overflow status.
interface req_encoder_if;
    logic [7:0] in;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pend;
    logic       ovf;
    logic       ovf_clr;

    modport master (
        output in,
        output out_ready,
        output ovf_clr,
        input  out,
        input  out_valid,
        input  pend,
        input  ovf
    );

    modport slave (
        input  in,
        input  out_ready,
        input  ovf_clr,
        output out,
        output out_valid,
        output pend,
        output ovf
    );
endinterface

// File: rtl/req_encoder.sv
// Collects per-line request events into a pending vector and presents one encoded index
// at a time over a ready/valid handshake, with fixed or rotating priority.
module req_encoder #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input logic         clk,
    input logic         rst_n,
    req_encoder_if.slave bus
);

    logic [7:0] pend_q, pend_d, clear_mask;
    logic [2:0] out_q, out_d, last_q, last_d, last_eff, sel, idx;
    logic       out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic       transfer, free, found;

    always_comb begin
        transfer   = out_valid_q & bus.out_ready;
        clear_mask = '0;
        if (transfer) begin
            clear_mask[out_q] = 1'b1;
        end
        // A new event on the line being transferred re-arms it rather than overflowing.
        pend_d   = (pend_q & ~clear_mask) | bus.in;
        last_eff = transfer ? out_q : last_q;
        last_d   = last_eff;
        free     = ~out_valid_q | transfer;
        found    = |pend_d;

        sel = '0;
        idx = '0;
        if (ROUND_ROBIN != 0) begin
            // Walk the order backwards so the earliest candidate after last_eff wins.
            for (int k = 8; k >= 1; k--) begin
                idx = last_eff + 3'(k);
                if (pend_d[idx]) begin
                    sel = idx;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pend_d[i]) begin
                    sel = 3'(i);
                end
            end
        end

        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (free) begin
            out_valid_d = found;
            if (found) begin
                out_d = sel;
            end
        end

        ovf_d = ovf_q;
        if (|(bus.in & pend_q & ~clear_mask)) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 8'h00;
            out_q       <= 3'b000;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            last_q      <= 3'b111;
        end else begin
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
        end
    end

    assign bus.pend      = pend_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: fixed-priority and rotating instances run the same
// stimulus and are compared every cycle against an event-level model.
module tb_req_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmp_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    req_encoder_if b0 ();
    req_encoder_if b1 ();

    req_encoder #(.ROUND_ROBIN(0)) dut_fixed (.clk(clk), .rst_n(rst_n), .bus(b0));
    req_encoder #(.ROUND_ROBIN(1)) dut_rr    (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    logic [7:0] d_pend [2];
    logic [2:0] d_out  [2];
    logic       d_vld  [2];
    logic       d_ovf  [2];
    assign d_pend[0] = b0.pend;
    assign d_pend[1] = b1.pend;
    assign d_out[0]  = b0.out;
    assign d_out[1]  = b1.out;
    assign d_vld[0]  = b0.out_valid;
    assign d_vld[1]  = b1.out_valid;
    assign d_ovf[0]  = b0.ovf;
    assign d_ovf[1]  = b1.ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] i, input logic r, input logic c);
        b0.in = i;  b0.out_ready = r;  b0.ovf_clr = c;
        b1.in = i;  b1.out_ready = r;  b1.ovf_clr = c;
    endtask

    // Event-level model: a set of pending lines, one shown line, and a grant pointer.
    logic [7:0] m_pend [2];
    logic [2:0] m_out  [2];
    logic [2:0] m_last [2];
    logic       m_vld  [2];
    logic       m_ovf  [2];
    logic [7:0] mcm, mnxt;
    logic       mx;
    int         pick, cand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = 8'h00; m_out[m] = 3'd0; m_last[m] = 3'd7;
                m_vld[m] = 1'b0;   m_ovf[m] = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                mx   = m_vld[m] && b0.out_ready;
                mcm  = mx ? 8'(1 << m_out[m]) : 8'h00;
                mnxt = (m_pend[m] & ~mcm) | b0.in;
                if ((b0.in & m_pend[m] & ~mcm) != 8'h00) m_ovf[m] = 1'b1;
                else if (b0.ovf_clr) m_ovf[m] = 1'b0;
                if (mx) m_last[m] = m_out[m];
                if (!m_vld[m] || mx) begin
                    pick = -1;
                    if (m == 0) begin
                        for (int i = 0; i < 8; i++) if (pick < 0 && mnxt[i]) pick = i;
                    end else begin
                        for (int k = 1; k <= 8; k++) begin
                            cand = (int'(m_last[m]) + k) % 8;
                            if (pick < 0 && mnxt[cand]) pick = cand;
                        end
                    end
                    if (pick >= 0) begin
                        m_out[m] = 3'(pick);
                        m_vld[m] = 1'b1;
                    end else begin
                        m_vld[m] = 1'b0;
                    end
                end
                m_pend[m] = mnxt;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("model_vld[%0d]", m), 32'(d_vld[m]), 32'(m_vld[m]));
                chk($sformatf("model_out[%0d]", m), 32'(d_out[m]), 32'(m_out[m]));
                chk($sformatf("model_pend[%0d]", m), 32'(d_pend[m]), 32'(m_pend[m]));
                chk($sformatf("model_ovf[%0d]", m), 32'(d_ovf[m]), 32'(m_ovf[m]));
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_pend"}, 32'(d_pend[m]), 32'h00);
            chk({tag, "_out"},  32'(d_out[m]),  32'd0);
            chk({tag, "_vld"},  32'(d_vld[m]),  32'd0);
            chk({tag, "_ovf"},  32'(d_ovf[m]),  32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // Single event, one-cycle latency, then idle.
        drive(8'h01, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_out", 32'(d_out[0]), 32'd0);
        chk("single_vld", 32'(d_vld[0]), 32'd1);
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_idle_vld", 32'(d_vld[0]), 32'd0);
        chk("single_idle_pend", 32'(d_pend[0]), 32'h00);

        // Fixed priority burst A4 -> 2,5,7 with no bubbles.
        drive(8'hA4, 1'b1, 1'b0);
        @(negedge clk);
        chk("burst_out0", 32'(d_out[0]), 32'd2);
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("burst_out1", 32'(d_out[0]), 32'd5);
        chk("burst_vld1", 32'(d_vld[0]), 32'd1);
        @(negedge clk);
        chk("burst_out2", 32'(d_out[0]), 32'd7);
        @(negedge clk);
        chk("burst_end_vld", 32'(d_vld[0]), 32'd0);

        // Backpressure holds out and pend.
        drive(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("hold_out", 32'(d_out[0]), 32'd0);
            chk("hold_pend", 32'(d_pend[0]), 32'h11);
            if (c < 2) @(negedge clk);
        end
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("hold_release_out", 32'(d_out[0]), 32'd4);
        chk("hold_release_rr", 32'(d_out[1]), 32'd4);
        @(negedge clk);
        chk("hold_drain_vld", 32'(d_vld[0]), 32'd0);

        // Overflow: repeated event while pending, clear, set-wins-over-clear.
        drive(8'h08, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_first_ovf", 32'(d_ovf[0]), 32'd0);
        @(negedge clk);
        chk("ovf_set", 32'(d_ovf[0]), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_cleared", 32'(d_ovf[0]), 32'd0);
        drive(8'h08, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_set_wins", 32'(d_ovf[0]), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_cleared2", 32'(d_ovf[0]), 32'd0);
        // Event on the line being transferred re-arms it without overflow.
        drive(8'h08, 1'b1, 1'b0);
        @(negedge clk);
        chk("rearm_out", 32'(d_out[0]), 32'd3);
        chk("rearm_vld", 32'(d_vld[0]), 32'd1);
        chk("rearm_ovf", 32'(d_ovf[0]), 32'd0);
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("rearm_drain_vld", 32'(d_vld[0]), 32'd0);

        // Rotating priority: 0F twice, grants 0,1,2,3,0,1,2,3.
        drive(8'h0F, 1'b1, 1'b0);
        for (int g = 0; g < 8; g++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", g), 32'(d_out[1]), 32'(g % 4));
            chk("rr_ovf", 32'(d_ovf[1]), 32'd0);
            drive((g == 3) ? 8'h0F : 8'h00, 1'b1, 1'b0);
        end
        @(negedge clk);
        chk("rr_end_vld", 32'(d_vld[1]), 32'd0);

        // Asynchronous reset mid-burst.
        drive(8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_pend", 32'(d_pend[0]), 32'hFF);
        chk("full_out_fixed", 32'(d_out[0]), 32'd0);
        chk("full_out_rr", 32'(d_out[1]), 32'd4);
        drive(8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h02, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_reset_out", 32'(d_out[0]), 32'd1);
        chk("post_reset_rr", 32'(d_out[1]), 32'd1);
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_reset_idle", 32'(d_vld[1]), 32'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
